// File: rtl/fp32_div_sqrt_iter_unit.sv
// FP32 divide/sqrt, radix-2 restoring, one result bit per cycle; finished 28 cycles after req (2 for special/zero operands when RSD_FP_DIVSQRT_EARLY_OUT_EN is defined).
// No backpressure: acquire/req/release/flush handshake; result held in FINISHED until release.
module fp32_div_sqrt_iter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        acquire,
    input  logic        req,
    input  logic        isDivide,
    input  logic [31:0] dataInA,
    input  logic [31:0] dataInB,
    input  logic [2:0]  rm,
    input  logic        release_i,
    input  logic        flush,
    output logic        reserved,
    output logic        busy,
    output logic        finished,
    output logic [31:0] dataOut,
    output logic [4:0]  fflagsOut
);
    localparam logic [1:0] ST_FREE = 2'd0, ST_RESERVED = 2'd1, ST_COMPUTING = 2'd2, ST_FINISHED = 2'd3;
    localparam logic [1:0] PH_PREP = 2'd0, PH_ITER = 2'd1, PH_ROUND = 2'd2;
    localparam logic [2:0] RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [1:0]        state_q, state_d, phase_q;
    logic [4:0]        cnt_q;
    logic [31:0]       a_q, b_q;
    logic              div_q;
    logic [2:0]        rm_q;
    logic signed [9:0] exp_q;
    logic [28:0]       rem_q;
    logic [51:0]       opnd_q;
    logic [25:0]       quo_q;
    logic [31:0]       dout_q;
    logic [4:0]        flg_q;

    // operand classification (subnormals read as zero)
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        za, zb, ia, ib, na, nb, snan, sign_c, lt;
    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign ma     = {1'b1, a_q[22:0]};
    assign mb     = {1'b1, b_q[22:0]};
    assign za     = (ea == 8'h00);
    assign zb     = (eb == 8'h00);
    assign ia     = (ea == 8'hFF) && (a_q[22:0] == 23'h0);
    assign ib     = (eb == 8'hFF) && (b_q[22:0] == 23'h0);
    assign na     = (ea == 8'hFF) && (a_q[22:0] != 23'h0);
    assign nb     = (eb == 8'hFF) && (b_q[22:0] != 23'h0);
    assign snan   = (na & ~a_q[22]) | (div_q & nb & ~b_q[22]);
    assign sign_c = div_q ? (a_q[31] ^ b_q[31]) : a_q[31];
    assign lt     = (ma < mb);

    logic        spec_c, early_c;
    logic [31:0] spec_res_c;
    logic [4:0]  spec_flg_c;
    always_comb begin
        spec_c     = 1'b1;
        spec_res_c = QNAN;
        spec_flg_c = 5'b0;
        if (div_q) begin
            if (na | nb)                     spec_flg_c = {snan, 4'b0};
            else if ((ia & ib) | (za & zb))  spec_flg_c = 5'b10000;
            else if (ia)                     spec_res_c = {sign_c, 8'hFF, 23'h0};
            else if (ib | za)                spec_res_c = {sign_c, 31'h0};
            else if (zb) begin
                spec_res_c = {sign_c, 8'hFF, 23'h0};
                spec_flg_c = 5'b01000;
            end
            else                             spec_c = 1'b0;
        end else begin
            if (na)                          spec_flg_c = {snan, 4'b0};
            else if (za)                     spec_res_c = {sign_c, 31'h0};
            else if (a_q[31])                spec_flg_c = 5'b10000;
            else if (ia)                     spec_res_c = {1'b0, 8'hFF, 23'h0};
            else                             spec_c = 1'b0;
        end
    end

`ifdef RSD_FP_DIVSQRT_EARLY_OUT_EN
    assign early_c = div_q ? (na | nb | za | (zb & ~ia) | (ia & ib)) : (na | za | a_q[31]);
`else
    assign early_c = 1'b0;
`endif

    // prep: divide pre-shifts the dividend so the quotient lands in [1,2);
    // sqrt doubles the radicand for even biased exponents so the exponent halves exactly
    logic signed [9:0] exp_c;
    logic [28:0]       rem_c;
    logic [51:0]       opnd_c;
    always_comb begin
        if (div_q) begin
            exp_c  = $signed({2'b0, ea}) - $signed({2'b0, eb}) + 10'sd127 - $signed({9'b0, lt});
            rem_c  = lt ? {4'b0, ma, 1'b0} : {5'b0, ma};
            opnd_c = {28'b0, mb};
        end else begin
            exp_c  = $signed({3'b0, ea[7:1]}) + 10'sd63 + $signed({9'b0, ea[0]});
            rem_c  = 29'b0;
            opnd_c = ea[0] ? {1'b0, ma, 27'b0} : {ma, 1'b0, 27'b0};
        end
    end

    logic [28:0] rem_sh, trial, rem_nx;
    logic        qbit;
    always_comb begin
        if (div_q) begin
            rem_sh = rem_q;
            trial  = {5'b0, opnd_q[23:0]};
        end else begin
            rem_sh = {rem_q[26:0], opnd_q[51:50]};
            trial  = {1'b0, quo_q, 2'b01};
        end
        qbit   = (rem_sh >= trial);
        rem_nx = qbit ? (rem_sh - trial) : rem_sh;
        if (div_q) rem_nx = {rem_nx[27:0], 1'b0};
    end

    logic              guard, sticky, up, to_inf;
    logic [24:0]       sig_r;
    logic signed [9:0] exp_r;
    logic [31:0]       res_c;
    logic [4:0]        flg_c;
    always_comb begin
        guard  = quo_q[1];
        sticky = quo_q[0] | (rem_q != 29'b0);
        up     = 1'b0;
        case (rm_q)
            RM_RNE:  up = guard & (sticky | quo_q[2]);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign_c & (guard | sticky);
            RM_RUP:  up = ~sign_c & (guard | sticky);
            RM_RMM:  up = guard;
            default: up = 1'b0;
        endcase
        sig_r  = {1'b0, quo_q[25:2]} + {24'b0, up};
        exp_r  = exp_q + $signed({9'b0, sig_r[24]});
        to_inf = (rm_q == RM_RNE) | (rm_q == RM_RMM) | ((rm_q == RM_RUP) & ~sign_c) | ((rm_q == RM_RDN) & sign_c);
        res_c  = {sign_c, exp_r[7:0], sig_r[22:0]};
        flg_c  = {4'b0, guard | sticky};
        if (spec_c) begin
            res_c = spec_res_c;
            flg_c = spec_flg_c;
        end else if (exp_r >= 10'sd255) begin
            res_c = to_inf ? {sign_c, 8'hFF, 23'h0} : {sign_c, 8'hFE, 23'h7FFFFF};
            flg_c = 5'b00101;
        end else if (exp_r <= 10'sd0) begin
            res_c = {sign_c, 31'h0};
            flg_c = 5'b00011;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) state_d = ST_FREE;
        else begin
            case (state_q)
                ST_FREE:      if (acquire) state_d = ST_RESERVED;
                ST_RESERVED:  if (req) state_d = ST_COMPUTING;
                ST_COMPUTING: if (phase_q == PH_ROUND) state_d = ST_FINISHED;
                default:      if (release_i) state_d = acquire ? ST_RESERVED : ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FREE;
            phase_q <= PH_PREP;
            cnt_q   <= 5'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            div_q   <= 1'b0;
            rm_q    <= 3'd0;
            exp_q   <= 10'sd0;
            rem_q   <= 29'b0;
            opnd_q  <= 52'b0;
            quo_q   <= 26'b0;
            dout_q  <= 32'h0;
            flg_q   <= 5'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                phase_q <= PH_PREP;
                cnt_q   <= 5'd0;
            end else if (state_q == ST_RESERVED && req) begin
                a_q     <= dataInA;
                b_q     <= dataInB;
                div_q   <= isDivide;
                rm_q    <= rm;
                phase_q <= PH_PREP;
            end else if (state_q == ST_COMPUTING) begin
                case (phase_q)
                    PH_PREP: begin
                        exp_q   <= exp_c;
                        rem_q   <= rem_c;
                        opnd_q  <= opnd_c;
                        quo_q   <= 26'b0;
                        cnt_q   <= 5'd0;
                        phase_q <= early_c ? PH_ROUND : PH_ITER;
                    end
                    PH_ITER: begin
                        rem_q  <= rem_nx;
                        quo_q  <= {quo_q[24:0], qbit};
                        opnd_q <= div_q ? opnd_q : {opnd_q[49:0], 2'b00};
                        if (cnt_q == 5'd25) phase_q <= PH_ROUND;
                        else                cnt_q   <= cnt_q + 5'd1;
                    end
                    default: begin
                        dout_q <= res_c;
                        flg_q  <= flg_c;
                    end
                endcase
            end
        end
    end

    assign reserved  = (state_q == ST_RESERVED);
    assign busy      = (state_q != ST_FREE);
    assign finished  = (state_q == ST_FINISHED);
    assign dataOut   = dout_q;
    assign fflagsOut = flg_q;
endmodule

// File: tb/tb_fp32_div_sqrt_iter_unit.sv
// Scoreboard bench for fp32_div_sqrt_iter_unit: directed vectors, flush/reset abandonment, and random ops
// checked against an arithmetic reference model (exact integer quotient / integer square root).
module tb_fp32_div_sqrt_iter_unit;
    localparam logic [4:0]  FL_NV = 5'b10000, FL_DZ = 5'b01000, FL_OF = 5'b00100, FL_UF = 5'b00010, FL_NX = 5'b00001;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        acquire = 1'b0, req = 1'b0, isDivide = 1'b0, release_i = 1'b0, flush = 1'b0;
    logic [31:0] dataInA = 32'h0, dataInB = 32'h0;
    logic [2:0]  rm = 3'd0;
    logic        reserved, busy, finished;
    logic [31:0] dataOut;
    logic [4:0]  fflagsOut;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { logic [31:0] data; logic [4:0] flags; int due; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic fin_prev = 1'b0;

    fp32_div_sqrt_iter_unit dut (
        .clk(clk), .rst(rst), .acquire(acquire), .req(req), .isDivide(isDivide),
        .dataInA(dataInA), .dataInB(dataInB), .rm(rm), .release_i(release_i), .flush(flush),
        .reserved(reserved), .busy(busy), .finished(finished), .dataOut(dataOut), .fflagsOut(fflagsOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    // monitor: every rising finished pops one expected result
    always @(negedge clk) begin
        if (!rst && finished && !fin_prev) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_finish actual=%0h required=none", dataOut);
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_data", dataOut, mon_e.data);
                check("mon_flags", fflagsOut, mon_e.flags);
                check("mon_latency_cycle", cyc, mon_e.due);
            end
        end
        fin_prev <= finished;
    end

    function automatic longint isqrt(input longint n);
        longint r;
        r = longint'($sqrt(real'(n)));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // q = value scaled by 2^25 (truncated), st = discarded remainder was nonzero
    function automatic logic [36:0] round_pack(input logic s, input int e_in, input longint q, input bit st, input logic [2:0] m);
        longint kept;
        int low, e;
        bit inexact, tie, above, up, to_inf;
        e = e_in;
        kept = q >> 2;
        low = int'(q & 3);
        inexact = (low != 0) || st;
        tie = (low == 2) && !st;
        above = (low == 3) || ((low == 2) && st);
        case (m)
            3'd0:    up = above || (tie && (kept % 2 == 1));
            3'd2:    up = inexact && s;
            3'd3:    up = inexact && !s;
            3'd4:    up = above || tie;
            default: up = 0;
        endcase
        if (up) kept = kept + 1;
        if (kept == (longint'(1) << 24)) begin kept = longint'(1) << 23; e = e + 1; end
        to_inf = (m == 3'd0) || (m == 3'd4) || (m == 3'd3 && !s) || (m == 3'd2 && s);
        if (e >= 255) return {FL_OF | FL_NX, to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF}};
        if (e <= 0) return {FL_UF | FL_NX, {s, 31'h0}};
        return {inexact ? FL_NX : 5'b0, {s, e[7:0], kept[22:0]}};
    endfunction

    function automatic logic [36:0] ref_model(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        int ea, eb, e;
        bit za, zb, ia, ib, na, nb, sn;
        logic s;
        longint num, den, n, root;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        sn = (na && !a[22]) || (div && nb && !b[22]);
        if (div) begin
            s = a[31] ^ b[31];
            if (na || nb) return {sn ? FL_NV : 5'b0, QNAN};
            if ((ia && ib) || (za && zb)) return {FL_NV, QNAN};
            if (ia) return {5'b0, {s, 8'hFF, 23'h0}};
            if (ib) return {5'b0, {s, 31'h0}};
            if (zb) return {FL_DZ, {s, 8'hFF, 23'h0}};
            if (za) return {5'b0, {s, 31'h0}};
            num = longint'({1'b1, a[22:0]});
            den = longint'({1'b1, b[22:0]});
            e = ea - eb + 127;
            if (num < den) begin num = num * 2; e = e - 1; end
            return round_pack(s, e, (num << 25) / den, ((num << 25) % den) != 0, m);
        end
        s = a[31];
        if (na) return {sn ? FL_NV : 5'b0, QNAN};
        if (za) return {5'b0, {s, 31'h0}};
        if (s) return {FL_NV, QNAN};
        if (ia) return {5'b0, 32'h7F800000};
        num = longint'({1'b1, a[22:0]});
        e = ea - 127;
        if (e % 2 != 0) begin num = num * 2; e = e - 1; end
        n = num << 27;
        root = isqrt(n);
        return round_pack(s, e / 2 + 127, root, (n - root * root) != 0, m);
    endfunction

    function automatic int latency(input logic div, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = 28;
`ifdef RSD_FP_DIVSQRT_EARLY_OUT_EN
        if (div) begin
            if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) || a[30:23] == 0 ||
                (b[30:23] == 0 && a[30:23] != 8'hFF) || (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000)) lat = 2;
        end else if (a[30:23] == 8'hFF && a[22:0] != 0 || a[30:23] == 0 || a[31]) lat = 2;
`endif
        return lat;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 19))
            0: v[30:0] = 31'h0;
            1: v[30:0] = 31'h7F800000;
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[0] = 1'b1; end
            4: v[30:23] = 8'h00;
            5: v[30:23] = 8'($urandom_range(1, 4));
            6: v[30:23] = 8'($urandom_range(250, 254));
            7: v[20:0] = 21'h0;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                          input logic [31:0] xd, input logic [4:0] xf, input bit need_acq, input bit rel_acq);
        bit ok;
        if (need_acq) begin
            acquire = 1'b1;
            @(negedge clk);
            acquire = 1'b0;
        end
        check("reserved_before_req", reserved, 1'b1);
        isDivide = div; dataInA = a; dataInB = b; rm = m; req = 1'b1;
        sb_q.push_back('{xd, xf, cyc + 1 + latency(div, a, b)});
        @(negedge clk);
        req = 1'b0;
        check("busy_computing", {busy, reserved}, 2'b10);
        ok = 0;
        // noise on ignored inputs while computing
        for (int i = 0; i < 40; i++) begin
            acquire = 1'($urandom); req = 1'($urandom); release_i = 1'($urandom);
            isDivide = 1'($urandom); dataInA = $urandom; dataInB = $urandom; rm = 3'($urandom);
            @(negedge clk);
            if (finished) begin ok = 1; break; end
        end
        acquire = 1'b0; req = 1'b0; release_i = 1'b0;
        check("finish_within_bound", ok, 1'b1);
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                acquire = 1'($urandom); req = 1'($urandom);
                @(negedge clk);
            end
            acquire = 1'b0; req = 1'b0;
            check("hold_finished", finished, 1'b1);
            check("hold_data", dataOut, xd);
            check("hold_flags", fflagsOut, xf);
            release_i = 1'b1; acquire = rel_acq;
            @(negedge clk);
            release_i = 1'b0; acquire = 1'b0;
            check("after_release", {busy, reserved, finished}, rel_acq ? 3'b110 : 3'b000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [36:0] r;
        logic [31:0] a, b;
        logic [2:0]  m;
        logic        div;
        bit          need, ra;

        repeat (3) @(negedge clk);
        check("reset_flags_out", {reserved, busy, finished}, 3'b000);
        check("reset_dataOut", dataOut, 32'h0);
        check("reset_fflags", fflagsOut, 5'h0);
        check("reset_counter", dut.cnt_q, 5'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1, 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b0, 1, 0);
        run_op(1, 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, FL_NX, 1, 0);
        run_op(1, 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, FL_NX, 1, 0);
        run_op(0, 32'h40000000, 32'h12345678, 3'd0, 32'h3FB504F3, FL_NX, 1, 0);
        run_op(0, 32'hBF800000, 32'h0, 3'd0, QNAN, FL_NV, 1, 0);
        run_op(0, 32'h80000000, 32'h0, 3'd2, 32'h80000000, 5'b0, 1, 0);
        run_op(1, 32'h7F000000, 32'h00800000, 3'd1, 32'h7F7FFFFF, FL_OF | FL_NX, 1, 0);
        run_op(1, 32'h00800000, 32'h7F000000, 3'd0, 32'h0, FL_UF | FL_NX, 1, 0);
        run_op(1, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, FL_DZ, 1, 1);
        // release+acquire left the unit reserved: req straight away
        run_op(1, 32'hC0C00000, 32'h40000000, 3'd0, 32'hC0400000, 5'b0, 0, 0);

        // flush 10 cycles into a computation
        acquire = 1'b1; @(negedge clk); acquire = 1'b0;
        isDivide = 1'b1; dataInA = 32'h40C00000; dataInB = 32'h40000000; req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        check("flush_to_free", {busy, reserved, finished}, 3'b000);
        repeat (35) @(negedge clk);
        check("flush_no_finish", finished, 1'b0);
        run_op(1, 32'h3F800000, 32'h40000000, 3'd0, 32'h3F000000, 5'b0, 1, 0);

        // reset mid-computation
        acquire = 1'b1; @(negedge clk); acquire = 1'b0;
        isDivide = 1'b0; dataInA = 32'h40800000; req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1; #1;
        check("midreset_state", {busy, reserved, finished}, 3'b000);
        check("midreset_data", {dataOut, 27'h0, fflagsOut}, 64'h0);
        @(negedge clk); rst = 1'b0;
        repeat (35) @(negedge clk);
        check("midreset_no_finish", finished, 1'b0);

        need = 1;
        for (int k = 0; k < 80; k++) begin
            div = ($urandom_range(0, 2) != 0);
            a = rnd_fp(); b = rnd_fp(); m = 3'($urandom_range(0, 4));
            if (!div && $urandom_range(0, 3) != 0) a[31] = 1'b0;
            r = ref_model(div, a, b, m);
            ra = (k < 79) && ($urandom_range(0, 4) == 0);
            run_op(div, a, b, m, r[31:0], r[36:32], need, ra);
            need = !ra;
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
